// File: rtl/vm_wrport_sched_pkg.sv
// Shared types and constants for the vector-mask register file write path.
package nvio3_vm_pkg;

  localparam int VM_NREG = 8;

  typedef logic [2:0]   vm_reg_t;
  typedef logic [127:0] vm_dat_t;

  typedef struct packed {
    logic    v;
    vm_reg_t a;
    vm_dat_t d;
  } vm_wr_t;

endpackage

// File: rtl/vm_wrport_sched_rr_pick2.sv
// Two-winner round-robin picker. Winner B must target a different register than A.
module vm_rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0]    req_v,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [IW-1:0]      rr,
  output logic               a_v,
  output logic [IW-1:0]      a_idx,
  output logic               b_v,
  output logic [IW-1:0]      b_idx
);

  // Scan from rr with wrap; the first valid is A, the next valid with a different target is B.
  always_comb begin
    int          k;
    logic [AW-1:0] a_reg;
    a_v   = 1'b0;
    b_v   = 1'b0;
    a_idx = '0;
    b_idx = '0;
    a_reg = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(rr) + i) % NREQ;
      if (req_v[k]) begin
        if (!a_v) begin
          a_v   = 1'b1;
          a_idx = IW'(k);
          a_reg = req_reg[k*AW +: AW];
        end else if (!b_v && (req_reg[k*AW +: AW] != a_reg)) begin
          b_v   = 1'b1;
          b_idx = IW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/vm_wrport_sched.sv
// Write-port scheduler for the 8-entry mask register file: picks up to two
// result writes per cycle, registers them onto the file ports and keeps the
// pending-write scoreboard used by issue to stall dependent readers.
module vm_wrport_sched
  import nvio3_vm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WID  = 128,
  parameter int AW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_v,
  input  logic [NREQ*AW-1:0]  req_reg,
  input  logic [NREQ*WID-1:0] req_dat,
  output logic [NREQ-1:0]     req_rdy,
  input  logic                rsv_v,
  input  logic [AW-1:0]       rsv_reg,
  output logic [VM_NREG-1:0]  busy,
  output logic                wr0,
  output logic                wr1,
  output logic [AW-1:0]       wa0,
  output logic [AW-1:0]       wa1,
  output logic [WID-1:0]      i0,
  output logic [WID-1:0]      i1
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]      rr;
  logic               a_v, b_v;
  logic [IW-1:0]      a_idx, b_idx;
  logic [AW-1:0]      a_reg, b_reg;
  logic [WID-1:0]     a_dat, b_dat;
  logic [VM_NREG-1:0] busy_nxt;

  vm_rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW),
    .IW   (IW)
  ) u_pick (
    .req_v   (req_v),
    .req_reg (req_reg),
    .rr      (rr),
    .a_v     (a_v),
    .a_idx   (a_idx),
    .b_v     (b_v),
    .b_idx   (b_idx)
  );

  assign a_reg = req_reg[a_idx*AW +: AW];
  assign b_reg = req_reg[b_idx*AW +: AW];
  assign a_dat = req_dat[a_idx*WID +: WID];
  assign b_dat = req_dat[b_idx*WID +: WID];

  // Grants go out only to the two winners, and never while reset is held.
  always_comb begin
    req_rdy = '0;
    if (!rst) begin
      if (a_v) req_rdy[a_idx] = 1'b1;
      if (b_v) req_rdy[b_idx] = 1'b1;
    end
  end

  // Completing writes clear their bit; a new reservation is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (a_v) busy_nxt[a_reg] = 1'b0;
    if (b_v) busy_nxt[b_reg] = 1'b0;
    if (rsv_v) busy_nxt[rsv_reg] = 1'b1;
  end

  // Output port registers, scoreboard and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr0  <= 1'b0;
      wr1  <= 1'b0;
      wa0  <= '0;
      wa1  <= '0;
      i0   <= '0;
      i1   <= '0;
      busy <= '0;
      rr   <= '0;
    end else begin
      wr0  <= a_v;
      wr1  <= b_v;
      busy <= busy_nxt;
      if (a_v) begin
        wa0 <= a_reg;
        i0  <= a_dat;
      end
      if (b_v) begin
        wa1 <= b_reg;
        i1  <= b_dat;
      end
      if (b_v)
        rr <= (b_idx == IW'(NREQ - 1)) ? '0 : b_idx + IW'(1);
      else if (a_v)
        rr <= (a_idx == IW'(NREQ - 1)) ? '0 : a_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_vm_wrport_sched.sv
// Directed bench for vm_wrport_sched with a per-cycle reference model.
module tb_vm_wrport_sched;

  localparam int NREQ = 4;
  localparam int WID  = 128;
  localparam int AW   = 3;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_v;
  logic [NREQ*AW-1:0]  req_reg;
  logic [NREQ*WID-1:0] req_dat;
  logic [NREQ-1:0]     req_rdy;
  logic                rsv_v;
  logic [AW-1:0]       rsv_reg;
  logic [7:0]          busy;
  logic                wr0, wr1;
  logic [AW-1:0]       wa0, wa1;
  logic [WID-1:0]      i0, i1;

  int total = 0;
  int bad   = 0;

  vm_wrport_sched #(.NREQ(NREQ), .WID(WID), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_v   (req_v),
    .req_reg (req_reg),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .rsv_v   (rsv_v),
    .rsv_reg (rsv_reg),
    .busy    (busy),
    .wr0     (wr0),
    .wr1     (wr1),
    .wa0     (wa0),
    .wa1     (wa1),
    .i0      (i0),
    .i1      (i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model state: what the registered outputs must be right now.
  int          m_rr = 0;
  logic        m_wr0 = 0, m_wr1 = 0;
  logic [2:0]  m_wa0 = 0, m_wa1 = 0;
  logic [127:0] m_i0 = 0, m_i1 = 0;
  logic [7:0]  m_busy = 0;
  int          order[$];
  int          ga, gb;
  logic [3:0]  erdy;

  function automatic logic [2:0] reg_of(input int k);
    return req_reg[k*AW +: AW];
  endfunction

  // Inputs are stable around the falling edge: check every output, then advance the model.
  always @(negedge clk) begin
    order.delete();
    for (int i = 0; i < NREQ; i++)
      if (req_v[(m_rr + i) % NREQ]) order.push_back((m_rr + i) % NREQ);
    ga = -1;
    gb = -1;
    if (order.size() > 0) ga = order[0];
    for (int j = 1; j < order.size(); j++)
      if (gb < 0 && reg_of(order[j]) != reg_of(ga)) gb = order[j];
    erdy = '0;
    if (!rst) begin
      if (ga >= 0) erdy[ga] = 1'b1;
      if (gb >= 0) erdy[gb] = 1'b1;
    end

    chk("m_rdy",  req_rdy, erdy);
    chk("m_wr0",  wr0,  m_wr0);
    chk("m_wr1",  wr1,  m_wr1);
    chk("m_wa0",  wa0,  m_wa0);
    chk("m_wa1",  wa1,  m_wa1);
    chk("m_i0",   i0,   m_i0);
    chk("m_i1",   i1,   m_i1);
    chk("m_busy", busy, m_busy);

    if (rst) begin
      m_wr0 = 0; m_wr1 = 0; m_wa0 = 0; m_wa1 = 0;
      m_i0 = 0; m_i1 = 0; m_busy = 0; m_rr = 0;
    end else begin
      m_wr0 = (ga >= 0);
      m_wr1 = (gb >= 0);
      if (ga >= 0) begin
        m_wa0 = reg_of(ga);
        m_i0  = req_dat[ga*WID +: WID];
        m_busy[reg_of(ga)] = 1'b0;
      end
      if (gb >= 0) begin
        m_wa1 = reg_of(gb);
        m_i1  = req_dat[gb*WID +: WID];
        m_busy[reg_of(gb)] = 1'b0;
      end
      if (rsv_v) m_busy[rsv_reg] = 1'b1;
      if (gb >= 0)      m_rr = (gb + 1) % NREQ;
      else if (ga >= 0) m_rr = (ga + 1) % NREQ;
    end
  end

  task automatic set_req(input int k, input logic v, input logic [2:0] r, input logic [127:0] d);
    req_v[k]           = v;
    req_reg[k*AW +: AW] = r;
    req_dat[k*WID +: WID] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsv_v = 1'b0; rsv_reg = '0;
    req_v = '0; req_reg = '0; req_dat = '0;
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 3'(k), 128'(k + 1));

    // reset held two cycles with every requester valid
    step(); #1;
    chk("rst_rdy", req_rdy, 4'b0000);
    chk("rst_wr0", wr0, 1'b0);
    chk("rst_wr1", wr1, 1'b0);
    chk("rst_busy", busy, 8'h00);
    step();
    rst = 1'b0;
    #1 chk("rel_rdy01", req_rdy, 4'b0011);

    // fairness: pairs alternate {0,1},{2,3}
    step(); #1;
    chk("fair1_wa0", wa0, 3'd0);
    chk("fair1_wa1", wa1, 3'd1);
    chk("fair1_rdy", req_rdy, 4'b1100);
    step(); #1;
    chk("fair2_wa0", wa0, 3'd2);
    chk("fair2_wa1", wa1, 3'd3);
    chk("fair2_rdy", req_rdy, 4'b0011);
    step(); #1;
    chk("fair3_rdy", req_rdy, 4'b1100);
    step();
    req_v = '0;
    #1 chk("fair4_wa0", wa0, 3'd2);
    step();

    // dual grant with rr = 0
    set_req(0, 1'b1, 3'd2, 128'hA);
    set_req(2, 1'b1, 3'd5, 128'hB);
    #1 chk("dual_rdy", req_rdy, 4'b0101);
    step();
    req_v = '0;
    #1;
    chk("dual_wr0", wr0, 1'b1);
    chk("dual_wa0", wa0, 3'd2);
    chk("dual_i0",  i0,  128'hA);
    chk("dual_wr1", wr1, 1'b1);
    chk("dual_wa1", wa1, 3'd5);
    chk("dual_i1",  i1,  128'hB);
    chk("dual_busy", busy, 8'h00);

    // rr = 3 now: requester 3 must lead requester 0
    set_req(0, 1'b1, 3'd0, 128'hC0);
    set_req(3, 1'b1, 3'd3, 128'hC3);
    #1 chk("rr3_rdy", req_rdy, 4'b1001);
    step();
    req_v = '0;
    set_req(1, 1'b1, 3'd4, 128'h11);
    set_req(3, 1'b1, 3'd4, 128'h33);
    #1;
    chk("rr3_wa0", wa0, 3'd3);
    chk("rr3_i0",  i0,  128'hC3);
    chk("rr3_wa1", wa1, 3'd0);
    chk("conf_rdy1", req_rdy, 4'b0010);
    step();
    req_v[1] = 1'b0;
    #1;
    chk("conf1_wr0", wr0, 1'b1);
    chk("conf1_wa0", wa0, 3'd4);
    chk("conf1_i0",  i0,  128'h11);
    chk("conf1_wr1", wr1, 1'b0);
    chk("conf_rdy2", req_rdy, 4'b1000);
    step();
    req_v = '0;
    rsv_v = 1'b1; rsv_reg = 3'd6;
    #1;
    chk("conf2_wa0", wa0, 3'd4);
    chk("conf2_i0",  i0,  128'h33);
    chk("conf2_wr1", wr1, 1'b0);

    // scoreboard set, set-beats-clear, then clear
    step();
    set_req(0, 1'b1, 3'd6, 128'h66);
    #1 chk("sb_set", busy, 8'h40);
    step();
    rsv_v = 1'b0;
    set_req(0, 1'b1, 3'd6, 128'h67);
    #1;
    chk("sb_setwins", busy, 8'h40);
    chk("sb_wa0", wa0, 3'd6);
    step();
    req_v = '0;
    rsv_v = 1'b1; rsv_reg = 3'd3;
    #1;
    chk("sb_clear", busy, 8'h00);
    chk("sb_i0", i0, 128'h67);
    step();
    rsv_reg = 3'd6;
    set_req(1, 1'b1, 3'd3, 128'h31);
    #1 chk("sb_set3", busy, 8'h08);
    step();

    // reset in the same cycle as a grant and a reservation
    rsv_reg = 3'd7;
    set_req(1, 1'b0, 3'd3, 128'h31);
    set_req(0, 1'b1, 3'd1, 128'h99);
    rst = 1'b1;
    #1;
    chk("sb_mixed", busy, 8'h40);
    chk("mid_rdy", req_rdy, 4'b0000);
    step();
    rst = 1'b0; req_v = '0; rsv_v = 1'b0;
    #1;
    chk("mid_wr0", wr0, 1'b0);
    chk("mid_wa0", wa0, 3'd0);
    chk("mid_busy", busy, 8'h00);
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 3'(k), 128'(k + 5));
    #1 chk("mid_rr0", req_rdy, 4'b0011);
    step();
    req_v = '0;
    #1 chk("mid_wr1", wr1, 1'b1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
